countdown_stopwatch_core: RTL and testbench
===========================================

Name: countdown_stopwatch_core

Overview:
Consumer end of the tick interface. Takes the one-cycle 1 Hz tick pulse from the tick generator and maintains an MM:SS BCD time value. Counts down as a timer or up as a stopwatch, under start/stop, reset and preset-load controls. Outputs drive the seven-segment display mux and the alarm/LED logic.

Parameters:
MAX_MIN, 59, upper limit for minutes, in BCD-decoded decimal (1..99).
SEC_WRAP, 59, highest seconds value before rollover (fixed at 59; kept as a parameter for simulation speed-up only).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_tick  in  1  one-cycle count-enable pulse from the tick generator
i_mode  in  1  0 = countdown timer, 1 = stopwatch (count up)
i_start_stop  in  1  one-cycle pulse; toggles run/pause
i_clear  in  1  one-cycle pulse; returns to IDLE with the reload value
i_load  in  1  one-cycle pulse; captures the preset
i_preset_min  in  8  BCD minutes preset {tens,units}
i_preset_sec  in  8  BCD seconds preset {tens,units}
o_min  out  8  BCD minutes
o_sec  out  8  BCD seconds
o_running  out  1  high in RUN
o_expired  out  1  high in DONE
o_expire_pulse  out  1  one-cycle pulse on entry to DONE
o_load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- All outputs registered. On a sampled i_rst_n=0 edge: state=IDLE, mode latch=0, preset reg=00:00, o_min=o_sec=8'h00, all flags 0.
- States are IDLE, RUN, PAUSE, DONE.
- Control priority, per cycle: i_rst_n > i_clear > i_load > i_start_stop > i_tick. Lower-priority inputs in the same cycle are ignored, not queued.
- i_mode is sampled only in IDLE. It is latched on the IDLE->RUN transition, and changes while in RUN, PAUSE or DONE have no effect.
- i_load is accepted in IDLE, PAUSE and DONE; it is ignored in RUN.
  - Valid preset: each BCD digit <=9, seconds tens <=5, minutes value <=MAX_MIN.
  - Valid preset -> stored in the preset reg; o_min/o_sec take the preset on the next edge; state becomes IDLE.
  - Invalid preset -> stored values unchanged; o_load_err=1 for one cycle.
- i_clear from any state -> IDLE.
  - Timer mode: display = preset reg.
  - Stopwatch mode: display = 00:00.
- i_start_stop:
  - IDLE->RUN. Exception: timer mode with display 00:00 stays IDLE and no flag is raised.
  - RUN->PAUSE and PAUSE->RUN.
  - Ignored in DONE.
- A tick coincident with a start/stop pulse is dropped. The first count change happens on the next tick after entry to RUN.
- Counting: on i_tick in RUN only; the display updates on the same edge, so latency is one clock from the tick being sampled to the new value at the outputs. Ticks in IDLE, PAUSE and DONE are ignored.
- Timer decrement, as a BCD borrow chain:
  - Seconds units 0->9 with borrow.
  - Seconds tens 0->5 with borrow.
  - Minutes units 0->9 with borrow into minutes tens.
  - A decrement reaching 00:00 enters DONE on the same edge, with o_expire_pulse=1 for that one cycle and o_expired=1 held.
- Stopwatch increment, as a BCD carry chain:
  - Seconds 59->00 carries into minutes.
  - At MAX_MIN:59 the next tick does not wrap: the value holds, state enters DONE, and the expire pulse and flag assert as above.
- DONE holds the display until i_clear, i_load or reset. o_running=0 in DONE.
- Reset mid-count takes effect on that edge and discards the preset. A clear mid-count keeps the preset.
- Every o_min/o_sec value is legal BCD at all times; no intermediate illegal nibble is ever visible.

Test Plan:
- Reset: i_rst_n low 2 cycles -> o_min=00, o_sec=00, o_running=0, o_expired=0, o_expire_pulse=0.
- Timer basic:
  - Stimulus: load 01:02, start, 62 ticks.
  - Display sequence: 01:02, 01:01, 01:00, 00:59 ... 00:01, 00:00.
  - o_expire_pulse high exactly one cycle at the 62nd tick edge; o_expired stays high.
  - Further ticks leave 00:00.
- Pause/coincidence:
  - Start with a tick on the same cycle -> no change.
  - Next tick -> 01:01.
  - Stop pulse, then 5 ticks -> still 01:01.
  - Start, 1 tick -> 01:00.
- Stopwatch saturation, with MAX_MIN=1:
  - 119 ticks -> 01:59; next tick -> stays 01:59 and enters DONE.
  - i_clear -> 00:00, IDLE.
- Load rules:
  - Preset 8'h6A or 00:75 -> o_load_err pulse, display unchanged.
  - Load during RUN -> ignored.
  - Load and start in the same cycle in IDLE -> load wins, state stays IDLE.
- Zero start and priority:
  - Timer at 00:00 plus start -> stays IDLE.
  - i_clear and i_load together in PAUSE -> clear wins; display = old preset.

Source files
------------

// File: rtl/countdown_stopwatch_core.sv
// countdown_stopwatch_core: MM:SS BCD timer / stopwatch driven by a 1 Hz tick.
// Counts down to 00:00 or up to MAX_MIN:59, then holds in DONE.
module countdown_stopwatch_core #(
  parameter int MAX_MIN  = 59,
  parameter int SEC_WRAP = 59
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_mode,
  input  logic       i_start_stop,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [7:0] i_preset_min,
  input  logic [7:0] i_preset_sec,
  output logic [7:0] o_min,
  output logic [7:0] o_sec,
  output logic       o_running,
  output logic       o_expired,
  output logic       o_expire_pulse,
  output logic       o_load_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] MAX_BCD  =
    {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0] WRAP_BCD =
    {4'(SEC_WRAP / 10), 4'(SEC_WRAP % 10)};

  logic [1:0] state;
  logic       mode_q;
  logic [7:0] pre_min;
  logic [7:0] pre_sec;
  logic [7:0] min_q;
  logic [7:0] sec_q;
  logic       pulse_q;
  logic       err_q;

  logic       mode_eff;
  logic       is_zero;
  logic       load_ok;
  logic [7:0] dec_min;
  logic [7:0] dec_sec;
  logic       dec_zero;
  logic [7:0] inc_min;
  logic [7:0] inc_sec;
  logic       inc_sat;

  // Mode is only live in IDLE; elsewhere the value latched at start rules.
  assign mode_eff = (state == S_IDLE) ? i_mode : mode_q;
  assign is_zero  = (min_q == 8'h00) && (sec_q == 8'h00);

  assign load_ok = (i_preset_min[7:4] <= 4'd9) &&
                   (i_preset_min[3:0] <= 4'd9) &&
                   (i_preset_sec[7:4] <= 4'd5) &&
                   (i_preset_sec[3:0] <= 4'd9) &&
                   (i_preset_min <= MAX_BCD);

  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    if (sec_q == 8'h00) begin
      dec_sec = WRAP_BCD;
      if (min_q[3:0] == 4'd0)
        dec_min = {min_q[7:4] - 4'd1, 4'd9};
      else
        dec_min = {min_q[7:4], min_q[3:0] - 4'd1};
    end else if (sec_q[3:0] == 4'd0) begin
      dec_sec = {sec_q[7:4] - 4'd1, 4'd9};
    end else begin
      dec_sec = {sec_q[7:4], sec_q[3:0] - 4'd1};
    end
    dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);
  end

  always_comb begin
    inc_min = min_q;
    inc_sec = sec_q;
    if (sec_q == WRAP_BCD) begin
      inc_sec = 8'h00;
      if (min_q[3:0] == 4'd9)
        inc_min = {min_q[7:4] + 4'd1, 4'd0};
      else
        inc_min = {min_q[7:4], min_q[3:0] + 4'd1};
    end else if (sec_q[3:0] == 4'd9) begin
      inc_sec = {sec_q[7:4] + 4'd1, 4'd0};
    end else begin
      inc_sec = {sec_q[7:4], sec_q[3:0] + 4'd1};
    end
    inc_sat = (min_q >= MAX_BCD) && (sec_q == WRAP_BCD);
  end

  always_ff @(posedge i_clk) begin
    pulse_q <= 1'b0;
    err_q   <= 1'b0;
    if (!i_rst_n) begin
      state   <= S_IDLE;
      mode_q  <= 1'b0;
      pre_min <= 8'h00;
      pre_sec <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
    end else if (i_clear) begin
      state <= S_IDLE;
      if (mode_eff) begin
        min_q <= 8'h00;
        sec_q <= 8'h00;
      end else begin
        min_q <= pre_min;
        sec_q <= pre_sec;
      end
    end else if (i_load && state != S_RUN) begin
      if (load_ok) begin
        pre_min <= i_preset_min;
        pre_sec <= i_preset_sec;
        min_q   <= i_preset_min;
        sec_q   <= i_preset_sec;
        state   <= S_IDLE;
      end else begin
        err_q <= 1'b1;
      end
    end else if (i_start_stop) begin
      unique case (state)
        S_IDLE: begin
          if (i_mode || !is_zero) begin
            state  <= S_RUN;
            mode_q <= i_mode;
          end
        end
        S_RUN:   state <= S_PAUSE;
        S_PAUSE: state <= S_RUN;
        default: state <= state;
      endcase
    end else if (i_tick && state == S_RUN) begin
      if (mode_q) begin
        if (inc_sat) begin
          state   <= S_DONE;
          pulse_q <= 1'b1;
        end else begin
          min_q <= inc_min;
          sec_q <= inc_sec;
        end
      end else begin
        min_q <= dec_min;
        sec_q <= dec_sec;
        if (dec_zero) begin
          state   <= S_DONE;
          pulse_q <= 1'b1;
        end
      end
    end
  end

  assign o_min          = min_q;
  assign o_sec          = sec_q;
  assign o_running      = (state == S_RUN);
  assign o_expired      = (state == S_DONE);
  assign o_expire_pulse = pulse_q;
  assign o_load_err     = err_q;

endmodule

// File: tb/tb_countdown_stopwatch_core.sv
// tb_countdown_stopwatch_core: directed scenario tasks with inline checks.
// DUT built with MAX_MIN=1 so stopwatch saturation is reachable quickly.
module tb_countdown_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       mode = 1'b0;
  logic       ss = 1'b0;
  logic       clr = 1'b0;
  logic       ld = 1'b0;
  logic [7:0] pmin = 8'h00;
  logic [7:0] psec = 8'h00;
  logic [7:0] o_min;
  logic [7:0] o_sec;
  logic       o_running;
  logic       o_expired;
  logic       o_expire_pulse;
  logic       o_load_err;

  int n_run = 0;
  int n_fail = 0;

  countdown_stopwatch_core #(.MAX_MIN(1), .SEC_WRAP(59)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_tick(tick),
    .i_mode(mode),
    .i_start_stop(ss),
    .i_clear(clr),
    .i_load(ld),
    .i_preset_min(pmin),
    .i_preset_sec(psec),
    .o_min(o_min),
    .o_sec(o_sec),
    .o_running(o_running),
    .o_expired(o_expired),
    .o_expire_pulse(o_expire_pulse),
    .o_load_err(o_load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mmss(input int t);
    int m;
    int s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic cyc(input logic t, input logic s,
                     input logic c, input logic l);
    tick = t;
    ss = s;
    clr = c;
    ld = l;
    @(posedge clk);
    #1;
    tick = 1'b0;
    ss = 1'b0;
    clr = 1'b0;
    ld = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    n_run++;
    if ({o_min, o_sec} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_disp got %h want 0000", {o_min, o_sec});
    end
    n_run++;
    if ({o_running, o_expired, o_expire_pulse, o_load_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000",
               {o_running, o_expired, o_expire_pulse, o_load_err});
    end
  endtask

  task automatic test_timer_basic;
    mode = 1'b0;
    pmin = 8'h01;
    psec = 8'h02;
    cyc(0, 0, 0, 1);
    n_run++;
    if ({o_min, o_sec, o_running} !== {16'h0102, 1'b0}) begin
      n_fail++;
      $display("FAIL tmr_load got %h/%b want 0102/0",
               {o_min, o_sec}, o_running);
    end
    cyc(0, 1, 0, 0);
    n_run++;
    if (o_running !== 1'b1) begin
      n_fail++;
      $display("FAIL tmr_start got %b want 1", o_running);
    end
    for (int i = 1; i <= 62; i++) begin
      cyc(1, 0, 0, 0);
      n_run++;
      if ({o_min, o_sec} !== mmss(62 - i)) begin
        n_fail++;
        $display("FAIL tmr_tick%0d got %h want %h",
                 i, {o_min, o_sec}, mmss(62 - i));
      end
      n_run++;
      if (o_expire_pulse !== (i == 62)) begin
        n_fail++;
        $display("FAIL tmr_pulse%0d got %b want %b",
                 i, o_expire_pulse, (i == 62));
      end
    end
    n_run++;
    if ({o_expired, o_running} !== 2'b10) begin
      n_fail++;
      $display("FAIL tmr_done got %b want 10", {o_expired, o_running});
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    n_run++;
    if ({o_min, o_sec, o_expired, o_expire_pulse} !== {16'h0000, 2'b10}) begin
      n_fail++;
      $display("FAIL tmr_hold got %h/%b%b want 0000/10",
               {o_min, o_sec}, o_expired, o_expire_pulse);
    end
  endtask

  task automatic test_pause;
    cyc(0, 0, 1, 0);
    n_run++;
    if ({o_min, o_sec, o_expired} !== {16'h0102, 1'b0}) begin
      n_fail++;
      $display("FAIL pz_clear got %h/%b want 0102/0",
               {o_min, o_sec}, o_expired);
    end
    cyc(1, 1, 0, 0);
    n_run++;
    if ({o_min, o_sec, o_running} !== {16'h0102, 1'b1}) begin
      n_fail++;
      $display("FAIL pz_coinc got %h/%b want 0102/1",
               {o_min, o_sec}, o_running);
    end
    cyc(1, 0, 0, 0);
    n_run++;
    if ({o_min, o_sec} !== 16'h0101) begin
      n_fail++;
      $display("FAIL pz_tick1 got %h want 0101", {o_min, o_sec});
    end
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    n_run++;
    if ({o_min, o_sec, o_running} !== {16'h0101, 1'b0}) begin
      n_fail++;
      $display("FAIL pz_paused got %h/%b want 0101/0",
               {o_min, o_sec}, o_running);
    end
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    n_run++;
    if ({o_min, o_sec, o_running} !== {16'h0100, 1'b1}) begin
      n_fail++;
      $display("FAIL pz_resume got %h/%b want 0100/1",
               {o_min, o_sec}, o_running);
    end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_priority;
    pmin = 8'h00;
    psec = 8'h30;
    cyc(0, 0, 1, 1);
    n_run++;
    if ({o_min, o_sec, o_running, o_load_err} !== {16'h0102, 2'b00}) begin
      n_fail++;
      $display("FAIL prio_clr_ld got %h/%b%b want 0102/00",
               {o_min, o_sec}, o_running, o_load_err);
    end
    cyc(0, 0, 1, 0);
    n_run++;
    if ({o_min, o_sec} !== 16'h0102) begin
      n_fail++;
      $display("FAIL prio_preset got %h want 0102", {o_min, o_sec});
    end
  endtask

  task automatic test_zero_start;
    pmin = 8'h00;
    psec = 8'h00;
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    n_run++;
    if ({o_min, o_sec, o_running, o_expired, o_expire_pulse}
        !== {16'h0000, 3'b000}) begin
      n_fail++;
      $display("FAIL zero_start got %h/%b%b%b want 0000/000",
               {o_min, o_sec}, o_running, o_expired, o_expire_pulse);
    end
    cyc(1, 0, 0, 0);
    n_run++;
    if ({o_min, o_sec, o_running} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_tick got %h/%b want 0000/0",
               {o_min, o_sec}, o_running);
    end
  endtask

  task automatic test_load_rules;
    pmin = 8'h6A;
    psec = 8'h00;
    cyc(0, 0, 0, 1);
    n_run++;
    if ({o_min, o_sec, o_load_err} !== {16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL ld_6A got %h/%b want 0000/1", {o_min, o_sec}, o_load_err);
    end
    cyc(0, 0, 0, 0);
    n_run++;
    if (o_load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_err_len got %b want 0", o_load_err);
    end
    pmin = 8'h00;
    psec = 8'h75;
    cyc(0, 0, 0, 1);
    n_run++;
    if ({o_min, o_sec, o_load_err} !== {16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL ld_75 got %h/%b want 0000/1", {o_min, o_sec}, o_load_err);
    end
    pmin = 8'h02;
    psec = 8'h00;
    cyc(0, 0, 0, 1);
    n_run++;
    if ({o_min, o_sec, o_load_err} !== {16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL ld_max got %h/%b want 0000/1", {o_min, o_sec}, o_load_err);
    end
    pmin = 8'h01;
    psec = 8'h59;
    cyc(0, 0, 0, 1);
    n_run++;
    if ({o_min, o_sec, o_load_err} !== {16'h0159, 1'b0}) begin
      n_fail++;
      $display("FAIL ld_ok got %h/%b want 0159/0", {o_min, o_sec}, o_load_err);
    end
    pmin = 8'h00;
    psec = 8'h45;
    cyc(0, 1, 0, 1);
    n_run++;
    if ({o_min, o_sec, o_running} !== {16'h0045, 1'b0}) begin
      n_fail++;
      $display("FAIL ld_vs_start got %h/%b want 0045/0",
               {o_min, o_sec}, o_running);
    end
    cyc(0, 1, 0, 0);
    pmin = 8'h00;
    psec = 8'h10;
    cyc(0, 0, 0, 1);
    n_run++;
    if ({o_min, o_sec, o_running, o_load_err} !== {16'h0045, 2'b10}) begin
      n_fail++;
      $display("FAIL ld_in_run got %h/%b%b want 0045/10",
               {o_min, o_sec}, o_running, o_load_err);
    end
    cyc(1, 0, 0, 0);
    n_run++;
    if ({o_min, o_sec} !== 16'h0044) begin
      n_fail++;
      $display("FAIL ld_run_tick got %h want 0044", {o_min, o_sec});
    end
    cyc(0, 0, 1, 0);
    n_run++;
    if ({o_min, o_sec, o_running} !== {16'h0045, 1'b0}) begin
      n_fail++;
      $display("FAIL ld_clr_keep got %h/%b want 0045/0",
               {o_min, o_sec}, o_running);
    end
  endtask

  task automatic test_stopwatch;
    mode = 1'b1;
    cyc(0, 0, 1, 0);
    n_run++;
    if ({o_min, o_sec} !== 16'h0000) begin
      n_fail++;
      $display("FAIL sw_clear got %h want 0000", {o_min, o_sec});
    end
    cyc(0, 1, 0, 0);
    mode = 1'b0;
    for (int i = 1; i <= 119; i++) begin
      cyc(1, 0, 0, 0);
      n_run++;
      if ({o_min, o_sec, o_expire_pulse} !== {mmss(i), 1'b0}) begin
        n_fail++;
        $display("FAIL sw_tick%0d got %h/%b want %h/0",
                 i, {o_min, o_sec}, o_expire_pulse, mmss(i));
      end
    end
    cyc(1, 0, 0, 0);
    n_run++;
    if ({o_min, o_sec, o_expired, o_expire_pulse, o_running}
        !== {16'h0159, 3'b110}) begin
      n_fail++;
      $display("FAIL sw_sat got %h/%b%b%b want 0159/110",
               {o_min, o_sec}, o_expired, o_expire_pulse, o_running);
    end
    cyc(1, 0, 0, 0);
    n_run++;
    if ({o_min, o_sec, o_expired, o_expire_pulse} !== {16'h0159, 2'b10}) begin
      n_fail++;
      $display("FAIL sw_hold got %h/%b%b want 0159/10",
               {o_min, o_sec}, o_expired, o_expire_pulse);
    end
    cyc(0, 0, 1, 0);
    n_run++;
    if ({o_min, o_sec, o_expired, o_running} !== {16'h0000, 2'b00}) begin
      n_fail++;
      $display("FAIL sw_clr got %h/%b%b want 0000/00",
               {o_min, o_sec}, o_expired, o_running);
    end
  endtask

  task automatic test_reset_midcount;
    mode = 1'b0;
    pmin = 8'h00;
    psec = 8'h05;
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    n_run++;
    if ({o_min, o_sec} !== 16'h0004) begin
      n_fail++;
      $display("FAIL rm_tick got %h want 0004", {o_min, o_sec});
    end
    rst_n = 1'b0;
    cyc(1, 0, 0, 0);
    rst_n = 1'b1;
    n_run++;
    if ({o_min, o_sec, o_running} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL rm_reset got %h/%b want 0000/0",
               {o_min, o_sec}, o_running);
    end
    cyc(0, 0, 1, 0);
    n_run++;
    if ({o_min, o_sec} !== 16'h0000) begin
      n_fail++;
      $display("FAIL rm_preset got %h want 0000", {o_min, o_sec});
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_timer_basic();
    test_pause();
    test_priority();
    test_zero_start();
    test_load_rules();
    test_stopwatch();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
